// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU sequencer: ALU op codes, the
// op-code legality check and the controller state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // True only for the six op codes the ALU implements.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Illegal op codes produce a zero result.
// SLT is an unsigned compare; ADD/SUB wrap modulo 2^32.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  // Op-code decode and zero detect.
  always_comb begin
    result = 32'd0;
    case (alu_ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = (a < b) ? 32'd1 : 32'd0;
      ALU_NOR: result = ~(a | b);
      default: result = 32'd0;
    endcase
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted valid found searching
// upward from last_grant+1, wrapping at NUM_REQ-1 -> 0. No grant when
// enable is low.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int             idx_s;
  logic [ID_W-1:0] cand_s;
  logic           found_s;

  // Rotating priority search; the first hit wins so the grant is one-hot.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = 0;
    cand_s    = '0;
    if (enable) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        idx_s = int'(last_grant) + i;
        if (idx_s >= NUM_REQ) begin
          idx_s = idx_s - NUM_REQ;
        end else begin
          idx_s = idx_s;
        end
        cand_s = ID_W'(idx_s);
        if (!found_s && valid[cand_s]) begin
          found_s       = 1'b1;
          grant[cand_s] = 1'b1;
          grant_idx     = cand_s;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      grant     = '0;
      grant_idx = '0;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between NUM_REQ requesters. A request is granted
// round-robin in IDLE, its operands are registered, the ALU result is
// registered after one EXEC cycle, and it is then held on the response
// channel until accepted.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  busy
);

  logic [1:0]         state_r;
  logic               busy_r;
  logic [ID_W-1:0]    last_grant_r;
  logic [ID_W-1:0]    gnt_r;
  logic [3:0]         op_r;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic               rsp_valid_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic [31:0]        rsp_result_r;
  logic               rsp_zero_r;
  logic               rsp_err_r;

  logic               arb_en_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [3:0]         sel_op_s;
  logic [31:0]        sel_a_s;
  logic [31:0]        sel_b_s;
  logic [31:0]        alu_result_s;
  logic               alu_zero_s;

  // Grants are only offered in IDLE and never while reset is applied.
  assign arb_en_s = (state_r == IDLE) & rst_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_r),
    .enable     (arb_en_s),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s)
  );

  assign req_ready = grant_s;

  // One-hot mux of the granted requester's operands.
  always_comb begin
    sel_op_s = 4'd0;
    sel_a_s  = 32'd0;
    sel_b_s  = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_op_s = sel_op_s | (req_op[4*i +: 4]  & {4{grant_s[i]}});
      sel_a_s  = sel_a_s  | (req_a[32*i +: 32] & {32{grant_s[i]}});
      sel_b_s  = sel_b_s  | (req_b[32*i +: 32] & {32{grant_s[i]}});
    end
  end

  alu u_alu (
    .alu_ctrl (op_r),
    .a        (a_r),
    .b        (b_r),
    .result   (alu_result_s),
    .zero     (alu_zero_s)
  );

  // Sequencer: accept in IDLE, register ALU outputs in EXEC, hold in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      last_grant_r <= ID_W'(NUM_REQ - 1);
      gnt_r        <= '0;
      op_r         <= 4'd0;
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_result_r <= 32'd0;
      rsp_zero_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|grant_s) begin
            gnt_r   <= grant_idx_s;
            op_r    <= sel_op_s;
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            state_r <= EXEC;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        EXEC: begin
          rsp_result_r <= alu_result_s;
          rsp_zero_r   <= alu_zero_s;
          rsp_err_r    <= ~is_legal_op(op_r);
          rsp_id_r     <= gnt_r;
          rsp_valid_r  <= 1'b1;
          state_r      <= RESP;
          busy_r       <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
            last_grant_r <= gnt_r;
            state_r      <= IDLE;
            busy_r       <= 1'b0;
          end else begin
            state_r      <= RESP;
            busy_r       <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_zero   = rsp_zero_r;
  assign rsp_err    = rsp_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed cases followed by
// randomized traffic checked against a transaction-level reference model.
module tb_alu_share_ctrl;

  localparam int NR = 2;
  localparam int IW = $clog2(NR);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [4*NR-1:0] req_op;
  logic [32*NR-1:0] req_a;
  logic [32*NR-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_zero;
  logic            rsp_err;
  logic            busy;

  always #5 clk = ~clk;

  alu_share_ctrl #(.NUM_REQ(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Requester-side model: pending requests and their operands.
  logic        pend [NR];
  logic [3:0]  p_op [NR];
  logic [31:0] p_a  [NR];
  logic [31:0] p_b  [NR];
  int          last_g;

  logic [3:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference ALU straight from the op-code table.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic err);
    err = 1'b0;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: begin err = 1'b1; return 32'd0; end
    endcase
  endfunction

  // Round-robin rule: first pending requester after the last one served.
  function automatic int model_pick();
    for (int k = 1; k <= NR; k++) begin
      int c = (last_g + k) % NR;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]       = pend[i];
      req_op[4*i +: 4]   = p_op[i];
      req_a[32*i +: 32]  = p_a[i];
      req_b[32*i +: 32]  = p_b[i];
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    pend[i] = 1'b1; p_op[i] = op; p_a[i] = a; p_b[i] = b;
  endtask

  task automatic rand_vals(input int i);
    if ($urandom_range(0, 7) == 0) p_op[i] = 4'($urandom_range(0, 15));
    else                           p_op[i] = legal_ops[$urandom_range(0, 5)];
    p_a[i] = $urandom();
    p_b[i] = ($urandom_range(0, 3) == 0) ? p_a[i] : $urandom();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_val({tag, "_busy"},      32'(busy),      32'd0);
    check_val({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    check_val({tag, "_rsp_result"}, rsp_result,    32'd0);
    check_val({tag, "_rsp_zero"},  32'(rsp_zero),  32'd0);
    check_val({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
  endtask

  // One transaction, starting and ending at a falling edge in IDLE.
  // mode 0: granted requester re-requests randomly; 1: always re-requests;
  // 2: goes idle. Operand inputs are always scrambled after the accept.
  task automatic run_txn(input int hold, input int mode, output int obs_id);
    int          g;
    logic [31:0] e_res;
    logic        e_err;
    logic [NR-1:0] e_rdy;
    obs_id = -1;
    drive();
    #1;
    g = model_pick();
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    check_val("req_ready_idle", 32'(req_ready), 32'(e_rdy));
    check_val("busy_idle", 32'(busy), 32'd0);
    if (g < 0) begin
      @(negedge clk);
      return;
    end
    e_res = ref_alu(p_op[g], p_a[g], p_b[g], e_err);
    @(negedge clk);
    rand_vals(g);
    pend[g] = (mode == 1) ? 1'b1 : ((mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    drive();
    #1;
    check_val("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("exec_busy", 32'(busy), 32'd1);
    check_val("exec_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    obs_id = int'(rsp_id);
    for (int h = 0; h <= hold; h++) begin
      check_val("rsp_valid", 32'(rsp_valid), 32'd1);
      check_val("rsp_id", 32'(rsp_id), 32'(g));
      check_val("rsp_result", rsp_result, e_res);
      check_val("rsp_zero", 32'(rsp_zero), 32'(e_res == 32'd0));
      check_val("rsp_err", 32'(rsp_err), 32'(e_err));
      check_val("resp_busy", 32'(busy), 32'd1);
      check_val("resp_req_ready", 32'(req_ready), 32'd0);
      rsp_ready = (h == hold) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    last_g = g;
    check_val("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int id;
    int arb_seq [4] = '{0, 1, 0, 1};
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0; p_op[i] = 4'd0; p_a[i] = 32'd0; p_b[i] = 32'd0;
    end
    drive();
    last_g = NR - 1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD from requester 0.
    set_req(0, 4'b0010, 32'd5, 32'd7);
    run_txn(0, 2, id);
    check_val("add_id", 32'(id), 32'd0);

    // SUB to zero from requester 1.
    set_req(1, 4'b0110, 32'd9, 32'd9);
    run_txn(0, 2, id);
    check_val("sub_id", 32'(id), 32'd1);

    // Both continuously valid: alternate 0,1,0,1.
    rand_vals(0); pend[0] = 1'b1;
    rand_vals(1); pend[1] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      run_txn(0, 1, id);
      check_val("arb_order", 32'(id), 32'(arb_seq[t]));
    end
    pend[0] = 1'b0; pend[1] = 1'b0;

    // Backpressure: five stalled cycles, handshake in the sixth.
    set_req(1, 4'b0001, 32'h0F0F_0000, 32'h0000_00F0);
    run_txn(5, 2, id);

    // Illegal op, then unsigned SLT in both directions.
    set_req(0, 4'b0011, 32'h1234_5678, 32'h0000_0001);
    run_txn(0, 2, id);
    set_req(1, 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    run_txn(0, 2, id);
    set_req(0, 4'b0111, 32'h0000_0001, 32'hFFFF_FFFF);
    run_txn(0, 2, id);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          rand_vals(i);
          pend[i] = 1'b1;
        end
      end
      run_txn($urandom_range(0, 3), 0, id);
    end
    for (int t = 0; t < NR; t++) run_txn(0, 2, id);

    // Reset in EXEC: leave last grant at 0 first so a lost reset of the
    // round-robin pointer would pick requester 1.
    set_req(0, 4'b0010, 32'd1, 32'd2);
    run_txn(0, 2, id);
    set_req(0, 4'b0010, 32'd3, 32'd4);
    drive();
    @(negedge clk);
    check_val("mid_exec_busy", 32'(busy), 32'd1);
    pend[0] = 1'b1; pend[1] = 1'b1;
    rand_vals(0); rand_vals(1);
    drive();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) begin
      @(negedge clk);
      check_val("in_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("in_reset_req_ready", 32'(req_ready), 32'd0);
    end
    last_g = NR - 1;
    rst_n = 1'b1;
    run_txn(0, 2, id);
    check_val("post_reset_grant", 32'(id), 32'd0);
    run_txn(0, 2, id);
    check_val("post_reset_second", 32'(id), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
